free_list: RTL and testbench

- Circular free-physical-register queue directly upstream of the register alias table (RAT) in the rename stage.
- Supplies one free preg per dest-writing decode slot, aligned to slot position, in the same cycle.
- Reclaims old pregs on commit.
- Rolls speculative allocations back to the committed (architectural) head on restore/flush.

---
 rtl/free_list_pkg.sv | 12 +
 rtl/free_list_prefix_popcount.sv | 22 ++
 rtl/free_list.sv | 117 +++++++++++
 tb/tb_free_list.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/free_list_pkg.sv
// rtl/free_list_pkg.sv - shared rename-stage types and sizing for the free list and RAT.
package free_list_pkg;

  localparam int PHY_REG_NUM  = 64;
  localparam int DECODE_WIDTH = 4;
  localparam int COMMIT_WIDTH = 2;
  localparam int PW           = $clog2(PHY_REG_NUM);

  typedef logic [PW-1:0] PRegIdxT;
  typedef logic [PW:0]   FlPtrT;

endpackage

// File: rtl/free_list_prefix_popcount.sv
// rtl/free_list_prefix_popcount.sv - per-bit exclusive prefix counts of a vector plus its total.
module prefix_popcount #(
  parameter int N  = 4,
  parameter int CW = $clog2(N + 1)
) (
  input  logic [N-1:0]         vec_i,
  output logic [N-1:0][CW-1:0] prefix_o,
  output logic [CW-1:0]        total_o
);

  logic [CW-1:0] acc;

  always_comb begin
    acc = '0;
    for (int i = 0; i < N; i++) begin
      prefix_o[i] = acc;
      acc = acc + CW'(vec_i[i]);
    end
    total_o = acc;
  end

endmodule

// File: rtl/free_list.sv
// rtl/free_list.sv - circular free physical register queue feeding the RAT.
// Speculative head allocates, arch head tracks commits, tail reclaims freed pregs.
module free_list #(
  parameter int  PHY_REG_NUM  = free_list_pkg::PHY_REG_NUM,
  parameter int  DECODE_WIDTH = free_list_pkg::DECODE_WIDTH,
  parameter int  COMMIT_WIDTH = free_list_pkg::COMMIT_WIDTH,
  localparam int PW           = $clog2(PHY_REG_NUM)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             alloc_valid_i,
  input  logic [DECODE_WIDTH-1:0]          alloc_req_i,
  output logic                             alloc_ready_o,
  output logic [DECODE_WIDTH-1:0][PW-1:0]  preg_o,
  input  logic [COMMIT_WIDTH-1:0]          commit_alloc_i,
  input  logic [COMMIT_WIDTH-1:0]          free_i,
  input  logic [COMMIT_WIDTH-1:0][PW-1:0]  free_preg_i,
  input  logic                             restore_i,
  output logic [PW:0]                      free_cnt_o
);

  import free_list_pkg::*;

  localparam int ACW = $clog2(DECODE_WIDTH + 1);
  localparam int CCW = $clog2(COMMIT_WIDTH + 1);

  logic [PW-1:0] entries_q [PHY_REG_NUM];
  logic [PW-1:0] entries_d [PHY_REG_NUM];
  logic [PW:0]   head_q, head_d;
  logic [PW:0]   arch_head_q, arch_head_d;
  logic [PW:0]   tail_q, tail_d;
  logic [PW:0]   count;
  logic          fire;

  logic [DECODE_WIDTH-1:0][ACW-1:0] alloc_prefix;
  logic [ACW-1:0]                   alloc_total;
  logic [COMMIT_WIDTH-1:0][CCW-1:0] free_prefix;
  logic [CCW-1:0]                   free_total;
  logic [COMMIT_WIDTH-1:0][CCW-1:0] commit_prefix;
  logic [CCW-1:0]                   commit_total;

  prefix_popcount #(.N(DECODE_WIDTH), .CW(ACW)) u_alloc_pc (
    .vec_i    (alloc_req_i),
    .prefix_o (alloc_prefix),
    .total_o  (alloc_total)
  );

  prefix_popcount #(.N(COMMIT_WIDTH), .CW(CCW)) u_free_pc (
    .vec_i    (free_i),
    .prefix_o (free_prefix),
    .total_o  (free_total)
  );

  prefix_popcount #(.N(COMMIT_WIDTH), .CW(CCW)) u_commit_pc (
    .vec_i    (commit_alloc_i),
    .prefix_o (commit_prefix),
    .total_o  (commit_total)
  );

  always_comb begin
    count         = tail_q - head_q;
    alloc_ready_o = !restore_i && (count >= (PW+1)'(alloc_total));
    fire          = alloc_valid_i && alloc_ready_o;

    // Slot i takes the entry after every lower requesting slot; index wraps mod depth.
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      preg_o[i] = entries_q[head_q[PW-1:0] + PW'(alloc_prefix[i])];
    end

    arch_head_d = arch_head_q + (PW+1)'(commit_total);
    head_d      = head_q;
    if (restore_i) begin
      head_d = arch_head_d;
    end else if (fire) begin
      head_d = head_q + (PW+1)'(alloc_total);
    end

    tail_d    = tail_q + (PW+1)'(free_total);
    entries_d = entries_q;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (free_i[k]) begin
        entries_d[tail_q[PW-1:0] + PW'(free_prefix[k])] = free_preg_i[k];
      end
    end
  end

  assign free_cnt_o = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PHY_REG_NUM; i++) begin
        entries_q[i] <= PW'(i);
      end
      head_q      <= '0;
      arch_head_q <= '0;
      tail_q      <= (PW+1)'(PHY_REG_NUM);
    end else begin
      entries_q   <= entries_d;
      head_q      <= head_d;
      arch_head_q <= arch_head_d;
      tail_q      <= tail_d;
    end
  end

  // Frees beyond capacity and commits past the speculative head are upstream bugs.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (32'(count) + 32'(free_total) <= 32'(PHY_REG_NUM));
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        if (commit_alloc_i[k]) begin
          assert ((PW+1)'(commit_prefix[k]) < (head_q - arch_head_q));
        end
      end
    end
  end

endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - directed and random self-checking bench for free_list.
module tb_free_list;
  import free_list_pkg::*;

  logic                            clk = 1'b0;
  logic                            rst_n = 1'b0;
  logic                            alloc_valid;
  logic [DECODE_WIDTH-1:0]         alloc_req;
  logic                            alloc_ready;
  logic [DECODE_WIDTH-1:0][PW-1:0] preg;
  logic [COMMIT_WIDTH-1:0]         commit_alloc;
  logic [COMMIT_WIDTH-1:0]         free_v;
  logic [COMMIT_WIDTH-1:0][PW-1:0] free_preg;
  logic                            restore;
  logic [PW:0]                     free_cnt;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Model: flist holds every preg from the arch head to the tail in order;
  // the first spec_n of them are speculatively allocated. live = committed pregs.
  int flist[$];
  int live[$];
  int spec_n;

  free_list dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alloc_valid_i  (alloc_valid),
    .alloc_req_i    (alloc_req),
    .alloc_ready_o  (alloc_ready),
    .preg_o         (preg),
    .commit_alloc_i (commit_alloc),
    .free_i         (free_v),
    .free_preg_i    (free_preg),
    .restore_i      (restore),
    .free_cnt_o     (free_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    flist.delete();
    for (int i = 0; i < PHY_REG_NUM; i++) flist.push_back(i);
    live.delete();
    spec_n = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      int pa, pc;
      bit rdy;
      pa  = $countones(alloc_req);
      pc  = $countones(commit_alloc);
      rdy = !restore && ((flist.size() - spec_n) >= pa);
      for (int k = 0; k < pc; k++) live.push_back(flist.pop_front());
      spec_n -= pc;
      if (restore) spec_n = 0;
      else if (alloc_valid && rdy) spec_n += pa;
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        if (free_v[k]) flist.push_back(int'(free_preg[k]));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      int cnt, p;
      cnt = flist.size() - spec_n;
      chk("model_free_cnt", 32'(free_cnt), cnt);
      chk("model_ready", 32'(alloc_ready), (!restore && cnt >= $countones(alloc_req)) ? 1 : 0);
      p = 0;
      for (int i = 0; i < DECODE_WIDTH; i++) begin
        if (alloc_req[i]) begin
          if (spec_n + p < flist.size())
            chk($sformatf("model_preg[%0d]", i), 32'(preg[i]), flist[spec_n + p]);
          p++;
        end
      end
    end
  end

  task automatic zero_inputs();
    alloc_valid  = 1'b0;
    alloc_req    = '0;
    commit_alloc = '0;
    free_v       = '0;
    free_preg    = '0;
    restore      = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    zero_inputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic rand_drive();
    int n, m, idx;
    alloc_req   = DECODE_WIDTH'($urandom_range(0, (1 << DECODE_WIDTH) - 1));
    alloc_valid = ($urandom_range(0, 9) < 7);
    restore     = ($urandom_range(0, 19) == 0);
    n = $urandom_range(0, (spec_n < 2) ? spec_n : 2);
    commit_alloc = (n == 2) ? 2'b11 : (n == 1) ? ($urandom_range(0, 1) ? 2'b01 : 2'b10) : 2'b00;
    m = $urandom_range(0, (live.size() < 2) ? live.size() : 2);
    free_v = (m == 2) ? 2'b11 : (m == 1) ? ($urandom_range(0, 1) ? 2'b01 : 2'b10) : 2'b00;
    free_preg = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (free_v[k]) begin
        idx = $urandom_range(0, live.size() - 1);
        free_preg[k] = PW'(live[idx]);
        live.delete(idx);
      end
    end
  endtask

  initial begin
    int seen[PHY_REG_NUM];
    int dups;
    zero_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_free_cnt", 32'(free_cnt), 64);
    chk("reset_ready", 32'(alloc_ready), 1);

    // Full group from reset
    @(posedge clk); #1;
    alloc_valid = 1'b1; alloc_req = 4'b1111;
    @(negedge clk);
    chk("a_preg0", 32'(preg[0]), 0);
    chk("a_preg1", 32'(preg[1]), 1);
    chk("a_preg2", 32'(preg[2]), 2);
    chk("a_preg3", 32'(preg[3]), 3);
    chk("a_ready", 32'(alloc_ready), 1);
    @(posedge clk); #1;
    alloc_valid = 1'b0; alloc_req = '0;
    @(negedge clk);
    chk("a_free_cnt", 32'(free_cnt), 60);

    // Sparse group
    do_reset();
    alloc_valid = 1'b1; alloc_req = 4'b1010;
    @(negedge clk);
    chk("b_preg1", 32'(preg[1]), 0);
    chk("b_preg3", 32'(preg[3]), 1);
    @(posedge clk); #1;
    alloc_valid = 1'b0; alloc_req = '0;
    @(negedge clk);
    chk("b_free_cnt", 32'(free_cnt), 62);

    // Drain to one entry, stall, then free 37 and see it handed out
    @(posedge clk); #1;
    alloc_valid = 1'b1; alloc_req = 4'b1111;
    repeat (15) @(posedge clk);
    #1;
    alloc_req = 4'b0001;
    @(posedge clk); #1;
    alloc_req = 4'b0011;
    @(negedge clk);
    chk("c_ready_low", 32'(alloc_ready), 0);
    chk("c_free_cnt1", 32'(free_cnt), 1);
    @(posedge clk); #1;
    free_v = 2'b01; free_preg[0] = 6'd37;
    @(negedge clk);
    chk("c_ready_prefree", 32'(alloc_ready), 0);
    chk("c_cnt_held", 32'(free_cnt), 1);
    @(posedge clk); #1;
    free_v = '0; free_preg = '0;
    @(negedge clk);
    chk("c_free_cnt2", 32'(free_cnt), 2);
    chk("c_ready_high", 32'(alloc_ready), 1);
    chk("c_preg0", 32'(preg[0]), 63);
    chk("c_preg1", 32'(preg[1]), 37);
    @(posedge clk); #1;
    alloc_valid = 1'b0; alloc_req = '0;
    @(negedge clk);
    chk("c_empty", 32'(free_cnt), 0);

    // Restore with no commits; allocation in restore cycle ignored
    do_reset();
    alloc_valid = 1'b1; alloc_req = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    restore = 1'b1;
    @(negedge clk);
    chk("d_free_cnt", 32'(free_cnt), 56);
    chk("d_ready_restore", 32'(alloc_ready), 0);
    @(posedge clk); #1;
    restore = 1'b0;
    @(negedge clk);
    chk("d_free_cnt_back", 32'(free_cnt), 64);
    chk("d_preg0", 32'(preg[0]), 0);

    // Restore together with a two-slot commit
    do_reset();
    alloc_valid = 1'b1; alloc_req = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    restore = 1'b1; commit_alloc = 2'b11;
    @(posedge clk); #1;
    restore = 1'b0; commit_alloc = '0; alloc_valid = 1'b0; alloc_req = 4'b0001;
    @(negedge clk);
    chk("e_free_cnt", 32'(free_cnt), 62);
    chk("e_preg0", 32'(preg[0]), 2);
    @(posedge clk); #1;
    restore = 1'b1;
    @(posedge clk); #1;
    restore = 1'b0;
    @(negedge clk);
    chk("e_arch_kept", 32'(free_cnt), 62);

    // Random traffic with wrap, plus an asynchronous reset mid-stream
    do_reset();
    for (int c = 0; c < 200; c++) begin
      rand_drive();
      if (c == 100) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_cnt", 32'(free_cnt), 64);
        chk("mid_reset_preg0", 32'(preg[0]), 0);
        @(posedge clk); #1;
        zero_inputs();
        rst_n = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    zero_inputs();
    @(posedge clk); #1;
    @(negedge clk);
    chk("conserve", 32'(int'(free_cnt) + spec_n + live.size()), 64);
    foreach (seen[i]) seen[i] = 0;
    dups = 0;
    foreach (flist[i]) begin
      if (seen[flist[i]] != 0) dups++;
      seen[flist[i]]++;
    end
    foreach (live[i]) begin
      if (seen[live[i]] != 0) dups++;
      seen[live[i]]++;
    end
    chk("no_duplicates", 32'(dups), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
